gmii_mac_tx: RTL
================

Name: gmii_mac_tx

Overview:
- Gigabit MAC transmit framer. Converts a byte stream from the packet engine into GMII transmit frames.
- Drives gmii_txd / gmii_tx_en / gmii_tx_er into the GMII-to-RGMII converter, on the converter's gmii_tx_clk.
- Inserts preamble, SFD, optional minimum-length padding and CRC-32 FCS, and enforces the inter-frame gap.
- Aborts frames on underrun or oversize using gmii_tx_er.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD.
- IFG_CYCLES, 12, idle cycles (tx_en low) after every frame or abort.
- MAX_LEN, 1514, maximum payload bytes excluding FCS; exceeding it aborts the frame.

Ports:
- gmii_tx_clk  in  1  transmit clock, 125 MHz.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- s_data  in  8  payload byte.
- s_valid  in  1  payload byte valid.
- s_last  in  1  marks the final payload byte of a frame.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- gmii_txd  out  8  GMII transmit data, registered.
- gmii_tx_en  out  1  GMII transmit enable, registered.
- gmii_tx_er  out  1  GMII transmit error, registered.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the last FCS byte is driven.
- underrun  out  1  one-cycle pulse on an abort (underrun or oversize).

Behaviour:
- Reset (async, reset_n=0): state IDLE. gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, s_ready=0, busy=0, frame_done=0, underrun=0, counters 0, CRC=0xFFFFFFFF.
- Reset mid-frame: outputs drop to these values immediately. The frame is truncated with no FCS. After release the block restarts in IDLE with no IFG.
- States and transitions:
  - IDLE -> PRE when s_valid=1 (s_ready=0 in IDLE).
  - PRE: drives 0x55, tx_en=1, for PREAMBLE_LEN cycles. The first 0x55 appears the cycle after s_valid is sampled high in IDLE.
  - SFD: drives 0xD5 for 1 cycle. s_ready=1 during this cycle.
  - DATA: the byte accepted in cycle N appears on gmii_txd in cycle N+1, so payload follows 0xD5 back-to-back. s_ready stays 1 until s_last is accepted. Each byte updates the CRC and the 11-bit payload counter.
  - On s_last accepted -> PAD (feature enabled and count<60) or FCS.
  - PAD: drives 0x00 and updates the CRC until count=60.
  - FCS: drives ~CRC, least-significant byte first, 4 cycles. frame_done pulses with the 4th byte. -> IFG.
  - IFG: tx_en=0, txd=0x00 for IFG_CYCLES cycles -> IDLE. s_valid is ignored during IFG.
- CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, byte processed LSB first. Covers payload and pad only, not preamble or SFD.
- Underrun: s_ready=1 and s_valid=0 in DATA or SFD.
  - Next cycle: tx_en=1, tx_er=1, txd=0x00 for 1 cycle; underrun pulses.
  - -> DROP: tx_en=0, s_ready=1, bytes discarded until s_last is accepted -> IFG.
  - If s_last was the byte just accepted, no underrun occurs.
- Oversize: accepting byte MAX_LEN+1 without s_last is treated exactly like underrun. That byte is not driven, and its s_last (if set) ends DROP immediately.
- Simultaneous reset and any event: reset wins.
- gmii_tx_er is never asserted except in the single abort cycle.

Optional Feature:
- GMII_TX_PAD_EN defined: frames with fewer than 60 payload bytes are zero-padded to 60 before the FCS (64-byte minimum frame).
- GMII_TX_PAD_EN undefined: no PAD state logic; FCS immediately follows the last payload byte for any length of 1 or more.

Test Plan:
- Without pad, payload ASCII "123456789" with s_valid held high -> 7x0x55, 0xD5, 31..39, then FCS 26 39 F4 CB. frame_done on the CB cycle. tx_en low for exactly 12 cycles, and tx_er never high.
- With GMII_TX_PAD_EN, 1-byte payload 0x00 -> 1 data + 59 pad bytes 0x00, then 4 FCS bytes matching a software CRC of 60 zero bytes. tx_en high for 8+64=72 cycles.
- Underrun: 20-byte frame with s_valid dropped after byte 10 -> 10 data bytes, one cycle tx_er=1/tx_en=1, underrun pulse, no FCS. Remaining 10 bytes are accepted silently, then a 12-cycle IFG.
- Oversize: 1515 bytes with s_last on byte 1515 -> 1514 bytes driven, abort cycle with tx_er=1, underrun pulse, then IFG. The next frame transmits normally.
- Back-to-back: second frame's s_valid high during IFG -> preamble of frame 2 starts exactly IFG_CYCLES+1 cycles after frame 1's last FCS byte.
- Reset asserted on payload byte 5 -> tx_en=0 and busy=0 the same cycle. After release, a new 9-byte frame is correct with init CRC.

Source files
------------

// File: rtl/gmii_mac_tx.sv
// GMII transmit framer: preamble/SFD, payload, CRC-32 FCS, inter-frame gap, tx_er abort on underrun/oversize.
// Define GMII_TX_PAD_EN to zero-pad payloads shorter than 60 bytes before the FCS.
module gmii_mac_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12,
  parameter int MAX_LEN      = 1514
) (
  input  logic       gmii_tx_clk,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
`ifdef GMII_TX_PAD_EN
    PAD,
`endif
    FCS,
    DROP,
    IFG
  } state_t;

  localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN);
  localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);
  localparam logic [10:0] LEN_MAX  = 11'(MAX_LEN);

  state_t      state, state_n;
  logic [10:0] cnt, cnt_n;
  logic [31:0] crc, crc_n, fcs;
  logic [7:0]  txd_n;
  logic        en_n, er_n, done_n, urun_n;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign fcs     = ~crc;
  assign s_ready = (state == SFD) || (state == DATA) || (state == DROP);
  assign busy    = (state != IDLE);

  // The registered outputs carry what this cycle's state decided, so the wire lags the state by one cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    crc_n   = crc;
    txd_n   = 8'h00;
    en_n    = 1'b0;
    er_n    = 1'b0;
    done_n  = 1'b0;
    urun_n  = 1'b0;
    case (state)
      IDLE: begin
        crc_n = 32'hFFFF_FFFF;
        cnt_n = '0;
        if (s_valid) begin
          state_n = PRE;
          txd_n   = 8'h55;
          en_n    = 1'b1;
          cnt_n   = 11'd1;
        end
      end
      PRE: begin
        en_n = 1'b1;
        if (cnt == PRE_LAST) begin
          txd_n   = 8'hD5;
          state_n = SFD;
          cnt_n   = '0;
        end else begin
          txd_n = 8'h55;
          cnt_n = cnt + 11'd1;
        end
      end
      SFD, DATA: begin
        if (!s_valid || cnt == LEN_MAX) begin
          // Abort cycle; an oversize byte carrying s_last needs no DROP phase.
          en_n    = 1'b1;
          er_n    = 1'b1;
          urun_n  = 1'b1;
          cnt_n   = '0;
          state_n = (s_valid && s_last) ? IFG : DROP;
        end else begin
          en_n    = 1'b1;
          txd_n   = s_data;
          crc_n   = crc_byte(crc, s_data);
          cnt_n   = cnt + 11'd1;
          state_n = DATA;
          if (s_last) begin
            state_n = FCS;
            cnt_n   = '0;
`ifdef GMII_TX_PAD_EN
            if (cnt + 11'd1 < 11'd60) begin
              state_n = PAD;
              cnt_n   = cnt + 11'd1;
            end
`endif
          end
        end
      end
`ifdef GMII_TX_PAD_EN
      PAD: begin
        en_n  = 1'b1;
        crc_n = crc_byte(crc, 8'h00);
        if (cnt == 11'd59) begin
          state_n = FCS;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 11'd1;
        end
      end
`endif
      FCS: begin
        en_n  = 1'b1;
        txd_n = fcs[{cnt[1:0], 3'b000} +: 8];
        if (cnt[1:0] == 2'd3) begin
          done_n  = 1'b1;
          state_n = IFG;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 11'd1;
        end
      end
      DROP: begin
        if (s_valid && s_last) begin
          state_n = IFG;
          cnt_n   = '0;
        end
      end
      IFG: begin
        if (cnt == IFG_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 11'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      crc        <= 32'hFFFF_FFFF;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      crc        <= crc_n;
      gmii_txd   <= txd_n;
      gmii_tx_en <= en_n;
      gmii_tx_er <= er_n;
      frame_done <= done_n;
      underrun   <= urun_n;
    end
  end

endmodule
